// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   OP_*      : operation encodings carried on in_op (101..111 reserved, pass-through)
//   clog2     : ceiling log2, used to size the amount field
//   calc_lat  : number of register ranks for a given amount width and stages-per-rank
package pipelined_barrel_shifter_pkg;

    localparam logic [2:0] OP_ROR = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_LSL = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // One rank after every spr log-stages, with the last rank possibly partial.
    function automatic int calc_lat(input int amt_w, input int spr);
        int l;
        l = (amt_w + spr - 1) / spr;
        return (l < 1) ? 1 : l;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// Single combinational log-stage: moves the word by DIST bit positions when en=1.
//   src  : word entering the stage
//   en   : amount bit for this stage
//   op   : operation; left ops use the left form, reserved ops pass through
//   fill : bit shifted into the vacated MSBs for ASR (original sign of the word)
//   res  : word leaving the stage
module shift_log_stage
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIST   = 1
) (
    input  logic [DATA_W-1:0] src,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic              fill,
    output logic [DATA_W-1:0] res
);

    always_comb begin
        res = src;
        if (en) begin
            case (op)
                OP_ROR:  res = {src[DIST-1:0], src[DATA_W-1:DIST]};
                OP_ROL:  res = {src[DATA_W-DIST-1:0], src[DATA_W-1:DATA_W-DIST]};
                OP_LSR:  res = {{DIST{1'b0}}, src[DATA_W-1:DIST]};
                OP_LSL:  res = {src[DATA_W-DIST-1:0], {DIST{1'b0}}};
                OP_ASR:  res = {{DIST{fill}}, src[DATA_W-1:DIST]};
                default: res = src;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit with valid/ready on both sides.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake; in_ready depends only on state and out_ready
//   in_data/in_amt/in_op  : operand, amount 0..DATA_W-1, operation (see package)
//   in_tag                : sideband carried unchanged
//   out_valid/out_ready   : output handshake
//   out_data/out_tag      : result and its tag, driven straight from the last rank
// AMT_W log-stages (LSB first) are grouped SPR per register rank; LAT ranks total.
module pipelined_barrel_shifter
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int SPR    = 2,
    parameter  int TAG_W  = 4,
    localparam int AMT_W  = clog2(DATA_W),
    localparam int LAT    = calc_lat(AMT_W, SPR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [2:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    // Rank registers, index r = rank r (1..LAT).
    logic [LAT:1]             vld_pipe;
    logic [LAT:1][DATA_W-1:0] data_q;
    logic [LAT:1][AMT_W-1:0]  amt_q;
    logic [LAT:1][2:0]        op_q;
    logic [LAT:1]             sign_q;
    logic [LAT:1][TAG_W-1:0]  tag_q;

    // Source feeding the stages of rank r+1: inputs for r=0, rank r registers otherwise.
    logic [DATA_W-1:0] src_data [LAT];
    logic [AMT_W-1:0]  src_amt  [LAT];
    logic [2:0]        src_op   [LAT];
    logic              src_sign [LAT];
    logic [TAG_W-1:0]  src_tag  [LAT];
    logic              src_vld  [LAT];

    logic [DATA_W-1:0] stg_res  [AMT_W];
    logic [DATA_W-1:0] rank_res [LAT];

    logic stall;

    assign stall    = vld_pipe[LAT] & ~out_ready;
    assign in_ready = ~stall;

    assign out_valid = vld_pipe[LAT];
    assign out_data  = data_q[LAT];
    assign out_tag   = tag_q[LAT];

    for (genvar r = 0; r < LAT; r++) begin : g_src
        if (r == 0) begin : g_in
            assign src_data[r] = in_data;
            assign src_amt[r]  = in_amt;
            assign src_op[r]   = in_op;
            // ASR fills with the operand's original MSB, not with whatever
            // intermediate stages have rotated into the top bit.
            assign src_sign[r] = in_data[DATA_W-1];
            assign src_tag[r]  = in_tag;
            assign src_vld[r]  = in_valid;
        end else begin : g_reg
            assign src_data[r] = data_q[r];
            assign src_amt[r]  = amt_q[r];
            assign src_op[r]   = op_q[r];
            assign src_sign[r] = sign_q[r];
            assign src_tag[r]  = tag_q[r];
            assign src_vld[r]  = vld_pipe[r];
        end
    end

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int R = k / SPR;
        logic [DATA_W-1:0] stg_src;

        // First stage of a rank starts from that rank's source, others chain.
        if (k % SPR == 0) begin : g_head
            assign stg_src = src_data[R];
        end else begin : g_chain
            assign stg_src = stg_res[k-1];
        end

        shift_log_stage #(
            .DATA_W (DATA_W),
            .DIST   (1 << k)
        ) u_stage (
            .src  (stg_src),
            .en   (src_amt[R][k]),
            .op   (src_op[R]),
            .fill (src_sign[R]),
            .res  (stg_res[k])
        );
    end

    for (genvar r = 0; r < LAT; r++) begin : g_rank
        localparam int LAST = (((r + 1) * SPR < AMT_W) ? (r + 1) * SPR : AMT_W) - 1;
        assign rank_res[r] = stg_res[LAST];
    end

    // Every rank advances together; a stall at the output freezes the whole pipe,
    // so nothing is lost or duplicated and bubbles only move when it runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            data_q   <= '0;
            amt_q    <= '0;
            op_q     <= '0;
            sign_q   <= '0;
            tag_q    <= '0;
        end else if (!stall) begin
            for (int r = 1; r <= LAT; r++) begin
                vld_pipe[r] <= src_vld[r-1];
                if (src_vld[r-1]) begin
                    data_q[r] <= rank_res[r-1];
                    amt_q[r]  <= src_amt[r-1];
                    op_q[r]   <= src_op[r-1];
                    sign_q[r] <= src_sign[r-1];
                    tag_q[r]  <= src_tag[r-1];
                end
            end
        end
    end

    // Amount bits already consumed and the last rank's control fields have no
    // readers; they are kept so every rank has the same register layout.
    logic unused_ok;
    assign unused_ok = ^{amt_q, op_q, sign_q};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
    import pipelined_barrel_shifter_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT: DATA_W=32, SPR=2
    logic        m_iv, m_irdy, m_ov, m_ordy;
    logic [31:0] m_id, m_od;
    logic [4:0]  m_ia;
    logic [2:0]  m_io;
    logic [3:0]  m_it, m_ot;
    // sweep DUTs: DATA_W=8, SPR=1 (a) and SPR=3 (b)
    logic        a_iv, a_irdy, a_ov, b_iv, b_irdy, b_ov;
    logic [7:0]  a_id, a_od, b_id, b_od;
    logic [2:0]  a_ia, a_io, b_ia, b_io;
    logic [3:0]  a_it, a_ot, b_it, b_ot;

    pipelined_barrel_shifter #(.DATA_W(32), .SPR(2), .TAG_W(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(m_iv), .in_ready(m_irdy),
        .in_data(m_id), .in_amt(m_ia), .in_op(m_io), .in_tag(m_it),
        .out_valid(m_ov), .out_ready(m_ordy), .out_data(m_od), .out_tag(m_ot));

    pipelined_barrel_shifter #(.DATA_W(8), .SPR(1), .TAG_W(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_iv), .in_ready(a_irdy),
        .in_data(a_id), .in_amt(a_ia), .in_op(a_io), .in_tag(a_it),
        .out_valid(a_ov), .out_ready(1'b1), .out_data(a_od), .out_tag(a_ot));

    pipelined_barrel_shifter #(.DATA_W(8), .SPR(3), .TAG_W(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_iv), .in_ready(b_irdy),
        .in_data(b_id), .in_amt(b_ia), .in_op(b_io), .in_tag(b_it),
        .out_valid(b_ov), .out_ready(1'b1), .out_data(b_od), .out_tag(b_ot));

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        int          cyc;
    } exp_t;

    exp_t mq[$], aq[$], bq[$];
    int   nchk = 0, nerr = 0, cyc = 0;
    bit   lat_on = 1'b0, use_exp = 1'b0;
    logic [31:0] exp_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: rotate/shift on a w-bit word using wide integer arithmetic.
    function automatic logic [31:0] model(input logic [31:0] d, input int n,
                                          input logic [2:0] op, input int w);
        logic [63:0] m, x, r;
        m = (64'd1 << w) - 64'd1;
        x = {32'd0, d} & m;
        case (op)
            3'd0:    r = (x >> n) | (x << (w - n));
            3'd1:    r = (x << n) | (x >> (w - n));
            3'd2:    r = x >> n;
            3'd3:    r = x << n;
            3'd4:    r = ((x >> (w - 1)) & 64'd1) != 0 ? ((x >> n) | (m & ~(m >> n))) : (x >> n);
            default: r = x;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    // One clock: score outputs and record accepted inputs, then advance.
    task automatic step();
        exp_t e;
        #1;
        if (m_ov && m_ordy) begin
            if (mq.size() == 0) check("m_extra", 32'(m_ov), 32'd0);
            else begin
                e = mq.pop_front();
                check("m_data", m_od, e.d);
                check("m_tag", 32'(m_ot), 32'(e.t));
                if (lat_on) check("m_lat", 32'(cyc - e.cyc), 32'(LAT));
            end
        end
        if (m_iv && m_irdy) begin
            e.d = use_exp ? exp_val : model(m_id, int'(m_ia), m_io, 32);
            e.t = m_it; e.cyc = cyc;
            mq.push_back(e);
        end
        if (a_ov) begin
            if (aq.size() == 0) check("a_extra", 32'(a_ov), 32'd0);
            else begin
                e = aq.pop_front();
                check("a_data", 32'(a_od), e.d);
                check("a_tag", 32'(a_ot), 32'(e.t));
            end
        end
        if (a_iv && a_irdy) begin
            e.d = model(32'(a_id), int'(a_ia), a_io, 8); e.t = a_it; e.cyc = cyc;
            aq.push_back(e);
        end
        if (b_ov) begin
            if (bq.size() == 0) check("b_extra", 32'(b_ov), 32'd0);
            else begin
                e = bq.pop_front();
                check("b_data", 32'(b_od), e.d);
                check("b_tag", 32'(b_ot), 32'(e.t));
            end
        end
        if (b_iv && b_irdy) begin
            e.d = model(32'(b_id), int'(b_ia), b_io, 8); e.t = b_it; e.cyc = cyc;
            bq.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [2:0] op,
                        input logic [3:0] t, input logic [31:0] x);
        int n = 0;
        m_iv = 1'b1; m_id = d; m_ia = a; m_io = op; m_it = t;
        exp_val = x; use_exp = 1'b1;
        while (!m_irdy && n < 50) begin step(); n++; end
        if (n == 50) check("send_timeout", 32'(m_irdy), 32'd1);
        step();
        m_iv = 1'b0; use_exp = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        m_iv = 1'b0; a_iv = 1'b0; b_iv = 1'b0; m_ordy = 1'b1;
        while ((mq.size() + aq.size() + bq.size()) != 0 && n < 100) begin step(); n++; end
        check("drain_left", 32'(mq.size() + aq.size() + bq.size()), 32'd0);
        repeat (2) step();
    endtask

    task automatic newword(input int i);
        m_id = $urandom;
        m_ia = 5'($urandom);
        m_io = 3'($urandom_range(0, 4));
        m_it = 4'(i);
    endtask

    // Random back-to-back stream; out_ready low for cycles [st_at, st_at+st_len).
    task automatic stream(input int nw, input int st_at, input int st_len);
        int i = 0, c = 0;
        bit acc;
        lat_on = (st_len == 0);
        m_iv = 1'b1;
        newword(0);
        while (i < nw && c < 200) begin
            m_ordy = !(c >= st_at && c < st_at + st_len);
            #1;
            if (st_len == 0) begin
                check("thru_in_rdy", 32'(m_irdy), 32'd1);
                if (c >= LAT) check("thru_out_vld", 32'(m_ov), 32'd1);
            end else if (!m_ordy) begin
                check("stall_in_rdy", 32'(m_irdy), 32'd0);
                check("stall_out_vld", 32'(m_ov), 32'd1);
                if (mq.size() != 0) begin
                    check("stall_data", m_od, mq[0].d);
                    check("stall_tag", 32'(m_ot), 32'(mq[0].t));
                end
            end
            acc = m_irdy;
            step();
            if (acc) begin i++; newword(i); end
            c++;
        end
        if (i < nw) check("stream_timeout", 32'(i), 32'(nw));
        m_iv = 1'b0; m_ordy = 1'b1;
    endtask

    initial begin
        m_iv = 0; m_id = 0; m_ia = 0; m_io = 0; m_it = 0; m_ordy = 1'b1;
        a_iv = 0; a_id = 0; a_ia = 0; a_io = 0; a_it = 0;
        b_iv = 0; b_id = 0; b_ia = 0; b_io = 0; b_it = 0;

        // reset state
        #3;
        check("rst_out_valid", 32'(m_ov), 32'd0);
        check("rst_out_data", m_od, 32'd0);
        check("rst_out_tag", 32'(m_ot), 32'd0);
        check("rst_in_ready", 32'(m_irdy), 32'd1);
        step(); step();
        reset_n = 1'b1;
        step();

        // directed cases with exact latency
        lat_on = 1'b1;
        send(32'h8000_0001, 5'd1,  OP_ROR, 4'd1, 32'hC000_0000);
        send(32'h8000_0001, 5'd4,  OP_ROL, 4'd2, 32'h0000_0018);
        send(32'hF000_0000, 5'd31, OP_LSR, 4'd3, 32'h0000_0001);
        send(32'hF000_0000, 5'd31, OP_ASR, 4'd4, 32'hFFFF_FFFF);
        send(32'h7000_0000, 5'd4,  OP_ASR, 4'd5, 32'h0700_0000);
        send(32'h0000_0001, 5'd31, OP_LSL, 4'd6, 32'h8000_0000);
        send(32'h1234_5678, 5'd0,  OP_ROR, 4'd7, 32'h1234_5678);
        send(32'h9234_5678, 5'd0,  OP_ASR, 4'd8, 32'h9234_5678);
        send(32'h1234_5678, 5'd0,  OP_LSL, 4'd9, 32'h1234_5678);
        send(32'hDEAD_BEEF, 5'd7,  3'b110, 4'd10, 32'hDEAD_BEEF);
        drain();

        // 16-word random stream at full rate, tags 0..15
        stream(16, 0, 0);
        drain();

        // backpressure with a full pipe
        stream(10, 5, 5);
        drain();

        // asynchronous reset with words in flight
        stream(3, 0, 0);
        check("rst_pre_out_valid", 32'(m_ov), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(m_ov), 32'd0);
        check("rst_async_data", m_od, 32'd0);
        check("rst_async_tag", 32'(m_ot), 32'd0);
        mq.delete();
        step();
        reset_n = 1'b1;
        repeat (6) begin
            check("rst_post_valid", 32'(m_ov), 32'd0);
            step();
        end
        lat_on = 1'b1;
        send(32'h0000_00F0, 5'd4, OP_LSR, 4'd11, 32'h0000_000F);
        drain();

        // exhaustive 8-bit sweep on both small configurations
        lat_on = 1'b0;
        a_iv = 1'b1; b_iv = 1'b1;
        for (int op = 0; op < 8; op++)
            for (int amt = 0; amt < 8; amt++)
                for (int d = 0; d < 256; d++) begin
                    a_id = 8'(d); a_ia = 3'(amt); a_io = 3'(op); a_it = 4'(d);
                    b_id = 8'(d); b_ia = 3'(amt); b_io = 3'(op); b_it = 4'(d + amt);
                    step();
                end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the 8-bit single-cycle rotate-right stage. It rotates or shifts a DATA_W-bit word by 0..DATA_W-1 in one of five modes. Log-stages are grouped behind pipeline registers, and a valid/ready handshake with backpressure sits on both sides. Used as a streaming datapath element between FIFOs and ALU-style blocks.

Parameters:
- DATA_W, 32, word width; power of 2, at least 4
- SPR, 2, log-stages per pipeline register; at least 1
- TAG_W, 4, width of the sideband tag carried alongside the data unmodified
- Derived: AMT_W = log2(DATA_W)
- Derived: LAT = ceil(AMT_W / SPR), the number of register ranks; at least 1

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts an input word this cycle
- in_data  in  DATA_W  operand
- in_amt  in  AMT_W  shift/rotate amount
- in_op  in  3  operation: 000 ROR, 001 ROL, 010 LSR, 011 LSL, 100 ASR; 101..111 reserved
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts a result
- out_data  out  DATA_W  result
- out_tag  out  TAG_W  tag of the word in out_data

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset_n=0: every rank's valid bit, data, amt, op and tag registers are 0, so out_valid=0, out_data=0, out_tag=0.
- Reset asserted mid-operation flushes all in-flight words; none emerge after release.
- Log-stage k (k = 0..AMT_W-1) acts on amt bit k with distance 2^k. Stages are ordered from LSB to MSB.
- A register rank follows every SPR stages. The last rank drives the outputs directly, with no combinational path from in_* to out_*.
- Latency is LAT cycles from an accepted input to out_valid, when no stall occurs.
- Handshake: stall = out_valid & ~out_ready, and in_ready = ~stall, so in_ready depends only on state and out_ready.
  - Input transfer happens when in_valid & in_ready. Output transfer happens when out_valid & out_ready.
  - On stall, all ranks hold: data, tag and valid are frozen, and there is no loss or duplication.
  - Bubbles (valid=0) advance when there is no stall.
  - Simultaneous input and output transfer sustains 1 word/cycle throughput.
- Per-mode result, with n = amt and W = DATA_W:
  - ROR: rotate right by n.
  - ROL: rotate left by n, identical to ROR by (W-n) mod W.
  - LSR: logical right, zero-fill MSBs.
  - LSL: logical left, zero-fill LSBs.
  - ASR: arithmetic right, fill with the original in_data[W-1]; the sign bit is captured at input and carried through the ranks.
  - n=0: output equals input in all modes.
  - n=W-1: LSR/LSL leave a single bit; ASR gives all sign bits.
- Reserved op: data passes unmodified, the tag is carried, and the word is not dropped.
- Direction handling: each stage carries op and the remaining amt bits in its rank registers. Left operations apply the left form of the stage; there is no bit-reversal pre/post pass.
- in_data, in_amt and in_op are don't-care when in_valid=0. Valid bits alone gate results.

Decomposition:
- Shared package holds:
  - op encodings: OP_ROR, OP_ROL, OP_LSR, OP_LSL, OP_ASR
  - the function clog2
  - the LAT computation
- Sub-module shift_log_stage, parameters DATA_W and DIST:
  - purely combinational single log-stage
  - inputs: data, enable bit, op, fill bit
  - output: data
- The top module instantiates AMT_W of these in a generate loop and places ranks every SPR stages.

Test Plan:
- DATA_W=32, SPR=2 (LAT=3), out_ready=1. ROR of 0x80000001 by 1 -> 0xC0000000; ROL of the same word by 4 -> 0x00000018. Each result appears exactly 3 cycles after acceptance, with tag preserved.
- LSR 0xF0000000 by 31 -> 0x00000001. ASR of the same word by 31 -> 0xFFFFFFFF. ASR 0x70000000 by 4 -> 0x07000000. LSL 0x00000001 by 31 -> 0x80000000. Amount 0 in any op -> unchanged.
- Back-to-back stream of 16 words with random op/amt and tags 0..15, out_ready=1. Checks: 1 word/cycle, in-order tags, results match the software model.
- Hold out_ready=0 for 5 cycles with a full pipeline. Checks: in_ready=0, outputs stable, no word lost; on release, drains in order.
- Assert reset_n=0 for 1 cycle with 3 words in flight. Checks: out_valid=0 and out_data=0 immediately (asynchronous); no stale words after release; the next accepted word emerges after LAT cycles.
- Reserved op 110 with data 0xDEADBEEF and amt 7 -> out_data 0xDEADBEEF. Sweep DATA_W=8, SPR=1 (LAT=3) and SPR=3 (LAT=1) with exhaustive data × amt × op against the model.
